// File: rtl/tpu_mac.sv
// tpu_mac: one processing element of a systolic matrix-multiply array.
// A is forwarded right and B downward through registers; signed A*B
// products accumulate in a local C register that can be loaded or chained
// through Cin/Cout.
// Build option: define TPU_MAC_SATURATE_EN to make accumulation saturate
// instead of wrapping. WrEn loads of Cin are never clamped.
module tpu_mac #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic signed [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic signed [BITS_C-1:0]  Cout
);

  // The accumulator must be able to hold at least one full product.
  generate
    if (BITS_C < 2 * BITS_AB) begin : g_width_check
      $error("tpu_mac: BITS_C must be >= 2*BITS_AB");
    end
  endgenerate

  logic signed [BITS_AB-1:0]   r_a;
  logic signed [BITS_AB-1:0]   r_b;
  logic signed [BITS_C-1:0]    r_c;
  logic signed [2*BITS_AB-1:0] w_prod;
  logic signed [BITS_C-1:0]    w_prod_ext;
  logic signed [BITS_C-1:0]    w_sum;
  logic signed [BITS_C-1:0]    w_acc_next;

  // The product uses the live inputs, not the forwarded registers.
  assign w_prod     = Ain * Bin;
  assign w_prod_ext = BITS_C'(w_prod);
  assign w_sum      = r_c + w_prod_ext;

`ifdef TPU_MAC_SATURATE_EN
  logic w_ovf_pos;
  logic w_ovf_neg;

  // Same-sign operands producing an opposite-sign result means overflow.
  assign w_ovf_pos = ~r_c[BITS_C-1] & ~w_prod_ext[BITS_C-1] &  w_sum[BITS_C-1];
  assign w_ovf_neg =  r_c[BITS_C-1] &  w_prod_ext[BITS_C-1] & ~w_sum[BITS_C-1];

  // Clamp the accumulated value to the representable range.
  always_comb begin
    w_acc_next = w_sum;
    if (w_ovf_pos) begin
      w_acc_next = {1'b0, {(BITS_C-1){1'b1}}};
    end else if (w_ovf_neg) begin
      w_acc_next = {1'b1, {(BITS_C-1){1'b0}}};
    end
  end
`else
  // Plain two's-complement wrap.
  always_comb begin
    w_acc_next = w_sum;
  end
`endif

  // Operand forwarding registers: advance only when the cell is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (en) begin
      r_a <= Ain;
      r_b <= Bin;
    end
  end

  // Accumulator: a load of Cin takes priority over a MAC step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c <= '0;
    end else if (WrEn) begin
      r_c <= Cin;
    end else if (en) begin
      r_c <= w_acc_next;
    end
  end

  assign Aout = r_a;
  assign Bout = r_b;
  assign Cout = r_c;

endmodule

// File: tb/tb_tpu_mac.sv
// Testbench for tpu_mac: directed vectors with literal expectations plus a
// per-cycle comparison against an integer-arithmetic reference model.
module tb_tpu_mac;
  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;
  localparam longint C_MAX = (64'sd1 <<< (BITS_C - 1)) - 1;
  localparam longint C_MIN = -(64'sd1 <<< (BITS_C - 1));
  localparam longint C_MOD = 64'sd1 <<< BITS_C;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic                      en = 1'b0;
  logic                      WrEn = 1'b0;
  logic signed [BITS_AB-1:0] Ain = '0;
  logic signed [BITS_AB-1:0] Bin = '0;
  logic signed [BITS_C-1:0]  Cin = '0;
  logic signed [BITS_AB-1:0] Aout;
  logic signed [BITS_AB-1:0] Bout;
  logic signed [BITS_C-1:0]  Cout;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, plain integers.
  longint m_a = 0;
  longint m_b = 0;
  longint m_c = 0;

  tpu_mac #(.BITS_AB(BITS_AB), .BITS_C(BITS_C)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .Aout(Aout), .Bout(Bout), .Cout(Cout)
  );

  always #5 clk = ~clk;

  function automatic longint acc(input longint c, input longint p);
    longint s;
    s = c + p;
`ifdef TPU_MAC_SATURATE_EN
    if (s > C_MAX) s = C_MAX;
    if (s < C_MIN) s = C_MIN;
`else
    s = ((s % C_MOD) + C_MOD) % C_MOD;
    if (s > C_MAX) s = s - C_MOD;
`endif
    return s;
  endfunction

  // Reference model: what the cell must hold after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_c = 0;
    end else begin
      if (WrEn) m_c = longint'(Cin);
      else if (en) m_c = acc(m_c, longint'(Ain) * longint'(Bin));
      if (en) begin
        m_a = longint'(Ain);
        m_b = longint'(Bin);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge: outputs must match the model.
  always @(negedge clk) begin
    check("model_aout", longint'(Aout), m_a);
    check("model_bout", longint'(Bout), m_b);
    check("model_cout", longint'(Cout), m_c);
    $display("cyc t=%0t en=%0b wr=%0b A=%0d B=%0d C=%0d", $time, en, WrEn, Aout, Bout, Cout);
  end

  // Drive one set of inputs and wait until just after the capturing edge.
  task automatic step(input logic e, input logic w, input int a, input int b, input int c);
    @(negedge clk);
    en = e; WrEn = w;
    Ain = BITS_AB'(a); Bin = BITS_AB'(b); Cin = BITS_C'(c);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1. Reset mid-operation clears outputs immediately and keeps them clear.
    step(1'b1, 1'b1, 5, 3, 7);
    check("pre_reset_cout", longint'(Cout), 7);
    check("pre_reset_aout", longint'(Aout), 5);
    @(negedge clk);
    WrEn = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_aout_async", longint'(Aout), 0);
    check("rst_bout_async", longint'(Bout), 0);
    check("rst_cout_async", longint'(Cout), 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_aout_held", longint'(Aout), 0);
    check("rst_cout_held", longint'(Cout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2. Load, then hold with everything disabled.
    step(1'b1, 1'b1, 0, 1, 1);
    check("load_cout", longint'(Cout), 1);
    check("load_aout", longint'(Aout), 0);
    check("load_bout", longint'(Bout), 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 77 + i, -9 - i, 1234);
      check("hold_cout", longint'(Cout), 1);
      check("hold_aout", longint'(Aout), 0);
      check("hold_bout", longint'(Bout), 1);
    end

    // 3. Signed accumulation.
    step(1'b0, 1'b1, 0, 0, 10);
    check("acc_preload", longint'(Cout), 10);
    step(1'b1, 1'b0, 3, 4, 0);
    check("acc1_cout", longint'(Cout), 22);
    check("acc1_aout", longint'(Aout), 3);
    check("acc1_bout", longint'(Bout), 4);
    step(1'b1, 1'b0, -2, 5, 0);
    check("acc2_cout", longint'(Cout), 12);
    check("acc2_aout", longint'(Aout), -2);
    check("acc2_bout", longint'(Bout), 5);
    step(1'b1, 1'b0, -128, -128, 0);
    check("acc3_cout", longint'(Cout), 16396);
    check("acc3_aout", longint'(Aout), -128);

    // 4. Load beats accumulate; operands still advance.
    step(1'b0, 1'b1, 0, 0, 100);
    check("prio_preload", longint'(Cout), 100);
    step(1'b1, 1'b1, 9, 9, -50);
    check("prio_cout", longint'(Cout), -50);
    check("prio_aout", longint'(Aout), 9);
    check("prio_bout", longint'(Bout), 9);

    // 5. Overflow at both ends of the range.
    step(1'b0, 1'b1, 0, 0, 32767);
    step(1'b1, 1'b0, 1, 1, 0);
`ifdef TPU_MAC_SATURATE_EN
    check("ovf_pos", longint'(Cout), 32767);
`else
    check("ovf_pos", longint'(Cout), -32768);
`endif
    step(1'b0, 1'b1, 0, 0, -32768);
    check("ovf_preload_min", longint'(Cout), -32768);
    step(1'b1, 1'b0, -1, 1, 0);
`ifdef TPU_MAC_SATURATE_EN
    check("ovf_neg", longint'(Cout), -32768);
`else
    check("ovf_neg", longint'(Cout), 32767);
`endif

    // 6. Random traffic, checked every cycle by the model comparison.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      en   = 1'($urandom_range(0, 1));
      WrEn = ($urandom_range(0, 7) == 0);
      Ain  = BITS_AB'($urandom);
      Bin  = BITS_AB'($urandom);
      Cin  = BITS_C'($urandom);
    end
    @(negedge clk);
    en = 1'b0; WrEn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
